dmem_store_buffer: RTL
======================

Name: dmem_store_buffer

Overview:
- Sits between the CPU data-memory port (lw/sw traffic) and a slower data memory with a valid/ready handshake.
- Buffers stores in a FIFO so the CPU retires sw without waiting for memory.
- Forwards buffered store data to matching loads.
- Stalls the CPU only when the buffer is full or a load misses the buffer.

Parameters:
DEPTH, 4, number of store entries; power of 2, at least 2
AW, 32, byte address width; matching uses bits [AW-1:2] (word granularity)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
cpu_write  input  1  store request (sw), held while cpu_stall=1
cpu_read  input  1  load request (lw), held while cpu_stall=1; never asserted together with cpu_write
cpu_address  input  AW  byte address, word aligned
cpu_write_data  input  32  store data
cpu_read_data  output  32  load data, valid in the cycle cpu_read=1 and cpu_stall=0
cpu_stall  output  1  CPU must hold its request and PC
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request when mem_valid=1 and mem_ready=1
mem_write  output  1  1 = write request, 0 = read request
mem_address  output  AW  request address
mem_write_data  output  32  write data
mem_rvalid  input  1  read response valid, one cycle, at least one cycle after read acceptance
mem_rdata  input  32  read response data

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; head/tail pointers and count set to 0; FSM goes to IDLE.
  - mem_valid=0, mem_write=0, cpu_stall=0, cpu_read_data=0.
  - Buffered stores are discarded. An in-flight memory read is abandoned; a late mem_rvalid is ignored.
- FIFO: count ranges 0..DEPTH; pointers wrap modulo DEPTH.
- Store enqueue:
  - cpu_write=1 and count<DEPTH: entry written at tail on the edge; cpu_stall=0 that cycle.
  - count==DEPTH: cpu_stall=1. A pop in the same cycle does not admit the store; it enters the following cycle.
- Load forwarding:
  - cpu_read=1: all valid entries are compared combinationally. The youngest matching entry supplies cpu_read_data with cpu_stall=0 (zero latency).
- Load miss: cpu_stall=1 and the FSM leaves IDLE. Loads bypass non-matching older stores.
- FSM states: IDLE, RD_REQ, RD_WAIT.
  - IDLE:
    - On a load miss, go to RD_REQ; read has priority over draining.
    - Otherwise, if count>0, drive mem_valid=1, mem_write=1, head address/data. Pop on handshake; the head stays stable until accepted.
  - RD_REQ: mem_valid=1, mem_write=0, address=cpu_address. On mem_ready, go to RD_WAIT.
  - RD_WAIT: mem_valid=0. On mem_rvalid: cpu_read_data=mem_rdata, cpu_stall=0 that cycle, go to IDLE.
- A write already presented with mem_valid=1 is never withdrawn (AXI-style stability) until accepted. A load miss arriving mid-drain waits in IDLE with cpu_stall=1 until that handshake completes, then goes to RD_REQ.
- A store and a drain pop in the same cycle with count<DEPTH: both happen; count is unchanged.
- Buffer empty with no request: mem_valid=0; outputs hold the last values.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - A store whose word address matches a valid entry that is not the head currently presented with mem_valid=1 overwrites that entry's data in place. No new entry is allocated and there is no stall, even when full.
  - If it matches only the presented head, a new entry is allocated normally.
- Undefined: every store allocates a new entry; duplicate addresses drain in program order.

Test Plan:
- Reset, then sw 0x10←0xAAAA_0001 with mem_ready=0 → no stall; count=1; mem_valid=1, mem_write=1, mem_address=0x10, mem_write_data=0xAAAA_0001.
- DEPTH=4, mem_ready=0, five sw to 0x00,0x04,0x08,0x0C,0x14 → first four take one cycle each; fifth sees cpu_stall=1. With mem_ready=1 for one cycle, the fifth is enqueued the cycle after the pop.
- sw 0x20←1, sw 0x20←2 buffered, then lw 0x20 → cpu_read_data=2 in the same cycle, cpu_stall=0. With STORE_BUF_COALESCE_EN, count=1 and not 2, provided the first store is not the presented head.
- Buffer empty, lw 0x40, mem_ready=1, mem_rvalid two cycles later with 0x1234_5678 → stall for 3 cycles; cpu_read_data=0x1234_5678 on the rvalid cycle; FSM returns to IDLE.
- Buffer holds a store to 0x50 presented with mem_ready=0, then lw 0x60 → the write stays presented, unchanged; after acceptance, a read request to 0x60 is issued.
- reset pulsed low while in RD_WAIT with 3 entries buffered → mem_valid=0 and count=0 immediately; a later mem_rvalid does not affect cpu_read_data or the FSM.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Store buffer between the CPU data port and a valid/ready data memory, with store-to-load forwarding.
// Optional build macro STORE_BUF_COALESCE_EN merges a store into a matching entry that is not being presented.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_write,
  input  logic          cpu_read,
  input  logic [AW-1:0] cpu_address,
  input  logic [31:0]   cpu_write_data,
  output logic [31:0]   cpu_read_data,
  output logic          cpu_stall,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [31:0]   mem_write_data,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_REQ = 2'd1, RD_WAIT = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [AW-3:0] addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg;
  logic          wr_pending_reg;
  logic [31:0]   rdata_reg;
  logic [AW-1:0] maddr_reg;
  logic [31:0]   mwdata_reg;
  logic          mwrite_reg;

  logic [AW-3:0]    cpu_word;
  logic [DEPTH-1:0] entry_match;
  logic             fwd_hit;
  logic [PW-1:0]    fwd_idx;
  logic             full, empty, load_miss, present_wr, push, pop, coal_wr;
  logic             mem_valid_c, mem_write_c, stall_c;
  logic [AW-1:0]    maddr_c;
  logic [31:0]      mwdata_c;

  assign cpu_word = cpu_address[AW-1:2];

  // An entry is live when its distance from head is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] age;
      assign age = PW'(gi) - head_reg;
      assign entry_match[gi] = ({1'b0, age} < count_reg) && (addr_mem[gi] == cpu_word);
    end
  endgenerate

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_match[head_reg + PW'(k)]) begin
        fwd_hit = 1'b1;
        fwd_idx = head_reg + PW'(k);
      end
    end
  end

  assign full       = count_reg == (PW+1)'(DEPTH);
  assign empty      = count_reg == '0;
  assign load_miss  = cpu_read && !fwd_hit;
  // A write that was presented and not yet accepted must stay on the bus.
  assign present_wr = (state_reg == IDLE) && !empty && (wr_pending_reg || !load_miss);
  assign pop        = present_wr && mem_ready;

`ifdef STORE_BUF_COALESCE_EN
  logic          coal_hit;
  logic [PW-1:0] coal_idx;

  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_match[head_reg + PW'(k)] && !(k == 0 && present_wr)) begin
        coal_hit = 1'b1;
        coal_idx = head_reg + PW'(k);
      end
    end
  end
  assign coal_wr = cpu_write && coal_hit;
`else
  assign coal_wr = 1'b0;
`endif

  assign push = cpu_write && !full && !coal_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_miss && (!wr_pending_reg || mem_ready)) state_next = RD_REQ;
      RD_REQ:  if (mem_ready) state_next = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_c   = 1'b0;
    mem_write_c   = 1'b0;
    maddr_c       = {addr_mem[head_reg], 2'b00};
    mwdata_c      = data_mem[head_reg];
    stall_c       = 1'b0;
    cpu_read_data = rdata_reg;
    case (state_reg)
      IDLE: begin
        mem_valid_c = present_wr;
        mem_write_c = present_wr;
        if (cpu_write && full && !coal_wr) stall_c = 1'b1;
        if (load_miss)     stall_c = 1'b1;
        else if (cpu_read) cpu_read_data = data_mem[fwd_idx];
      end
      RD_REQ: begin
        mem_valid_c = 1'b1;
        maddr_c     = cpu_address;
        stall_c     = 1'b1;
      end
      RD_WAIT: begin
        stall_c = !mem_rvalid;
        if (mem_rvalid) cpu_read_data = mem_rdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall      = stall_c && reset;
  assign mem_valid      = mem_valid_c;
  assign mem_write      = mem_valid_c ? mem_write_c : mwrite_reg;
  assign mem_address    = mem_valid_c ? maddr_c : maddr_reg;
  assign mem_write_data = mem_valid_c ? mwdata_c : mwdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      wr_pending_reg <= 1'b0;
      rdata_reg      <= '0;
      maddr_reg      <= '0;
      mwdata_reg     <= '0;
      mwrite_reg     <= 1'b0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      count_reg      <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
      wr_pending_reg <= mem_valid_c && mem_write_c && !mem_ready;
      rdata_reg      <= cpu_read_data;
      if (mem_valid_c) begin
        maddr_reg  <= maddr_c;
        mwdata_reg <= mwdata_c;
        mwrite_reg <= mem_write_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= cpu_word;
      data_mem[tail_reg] <= cpu_write_data;
    end
`ifdef STORE_BUF_COALESCE_EN
    if (coal_wr) data_mem[coal_idx] <= cpu_write_data;
`endif
  end
endmodule
